// File: rtl/node_xy_switch.sv
// node_xy_switch -- 4-port XY mesh router node.
//
// Each input port (0=N, 1=S, 2=E, 3=W) owns a small FIFO fed by an upstream
// head/pop handshake. The FIFO head is routed row-first or column-first
// toward the target node, fanned out to every other port when its payload
// equals the broadcast value, or dropped with an err pulse when it is
// addressed to this node. Each output port owns a round-robin arbiter and
// a holding register that is reloaded whenever it is empty or being consumed.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous active-low reset
//   pndng_in  in   [3:0] upstream head valid per port
//   data_in   in   [3:0][pckg_sz] upstream head data per port
//   popin     out  [3:0] pop strobe back to upstream (combinational)
//   pndng     out  [3:0] output holding register valid
//   data_out  out  [3:0][pckg_sz] output holding register data
//   pop       in   [3:0] downstream consume strobe
//   err       out  one-cycle pulse per dropped self-addressed packet
module node_xy_switch #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int id_row     = 1,
  parameter int id_column  = 1,
  parameter logic [pckg_sz-18:0] bdcst = {1'b0, {(pckg_sz-18){1'b1}}}
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              pndng_in,
  input  logic [3:0][pckg_sz-1:0] data_in,
  output logic [3:0]              popin,
  output logic [3:0]              pndng,
  output logic [3:0][pckg_sz-1:0] data_out,
  input  logic [3:0]              pop,
  output logic                    err
);

  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cw = $clog2(fifo_depth + 1);
  localparam logic [cw-1:0] depth_c = cw'(fifo_depth);
  localparam logic [aw-1:0] last_c  = aw'(fifo_depth - 1);
  localparam logic [3:0]    row_c   = 4'(id_row);
  localparam logic [3:0]    col_c   = 4'(id_column);

  logic [pckg_sz-1:0]        mem [4][fifo_depth];
  logic [3:0][aw-1:0]        rd_ptr;
  logic [3:0][aw-1:0]        wr_ptr;
  logic [3:0][cw-1:0]        count;
  logic [3:0][3:0]           sent;      // [input][output] copies already delivered
  logic [3:0][1:0]           rr_ptr;    // [output] highest-priority input
  logic [3:0][pckg_sz-1:0]   head;
  logic [3:0]                head_valid;
  logic [3:0]                is_self;
  logic [3:0]                head_pop;
  logic [3:0]                push;
  logic [3:0][3:0]           tgt;       // [input][output]
  logic [3:0][3:0]           req;       // [input][output]
  logic [3:0][3:0]           grant;     // [output][input]
  logic [3:0][3:0]           taken;     // [input][output]
  logic [3:0]                ready;
  logic [3:0]                gnt_any;
  logic [3:0][1:0]           gnt_idx;

  // Destination mask of a head packet; all-zero means addressed to this node.
  function automatic logic [3:0] route(input logic [pckg_sz-1:0] h, input logic [1:0] arr);
    logic [3:0] tr;
    logic [3:0] tc;
    logic [3:0] m;
    tr = h[pckg_sz-9 -: 4];
    tc = h[pckg_sz-13 -: 4];
    if (h[pckg_sz-18:0] == bdcst) begin
      m = ~(4'b0001 << arr);
    end else if ((tr == row_c) && (tc == col_c)) begin
      m = 4'b0000;
    end else if (h[pckg_sz-17] ? (tr != row_c) : (tc == col_c)) begin
      // Vertical move: rows differ in row-first mode, or columns already match.
      m = (tr < row_c) ? 4'b0001 : 4'b0010;
    end else begin
      m = (tc < col_c) ? 4'b1000 : 4'b0100;
    end
    return m;
  endfunction

  assign popin = push;
  assign ready = ~pndng | pop;

  // FIFO head decode, upstream pop and per-output requests.
  always_comb begin
    head       = '0;
    head_valid = '0;
    push       = '0;
    tgt        = '0;
    is_self    = '0;
    req        = '0;
    for (int i = 0; i < 4; i++) begin
      head[i]       = mem[i][rd_ptr[i]];
      head_valid[i] = (count[i] != '0);
      // A full FIFO refuses the push even if its head leaves this cycle.
      push[i]       = pndng_in[i] && (count[i] < depth_c) && reset;
      tgt[i]        = head_valid[i] ? route(head[i], 2'(i)) : 4'b0000;
      is_self[i]    = head_valid[i] && (tgt[i] == 4'b0000);
      req[i]        = tgt[i] & ~sent[i];
    end
  end

  // Round-robin arbitration per output, starting at that output's pointer.
  always_comb begin
    logic [1:0] idx;
    idx     = 2'd0;
    grant   = '0;
    gnt_any = '0;
    gnt_idx = '0;
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 4; k++) begin
        idx = rr_ptr[o] + 2'(k);
        if (ready[o] && !gnt_any[o] && req[idx][o]) begin
          gnt_any[o]       = 1'b1;
          gnt_idx[o]       = idx;
          grant[o][idx]    = 1'b1;
        end else begin
          grant[o][idx]    = grant[o][idx];
        end
      end
    end
  end

  // Head retirement: popped once every target copy has been delivered.
  always_comb begin
    taken    = '0;
    head_pop = '0;
    for (int i = 0; i < 4; i++) begin
      taken[i]    = {grant[3][i], grant[2][i], grant[1][i], grant[0][i]};
      head_pop[i] = head_valid[i] && ((tgt[i] & ~(sent[i] | taken[i])) == 4'b0000);
    end
  end

  // FIFO storage write; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= data_in[i];
      end
    end
  end

  // FIFO pointers, occupancy and broadcast sent masks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      sent   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= (wr_ptr[i] == last_c) ? '0 : wr_ptr[i] + aw'(1);
        end
        if (head_pop[i]) begin
          rd_ptr[i] <= (rd_ptr[i] == last_c) ? '0 : rd_ptr[i] + aw'(1);
        end
        count[i] <= count[i] + cw'(push[i]) - cw'(head_pop[i]);
        sent[i]  <= head_pop[i] ? 4'b0000 : (sent[i] | taken[i]);
      end
    end
  end

  // Output holding registers, arbiter pointers and the drop pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pndng    <= '0;
      data_out <= '0;
      rr_ptr   <= '0;
      err      <= 1'b0;
    end else begin
      err <= |is_self;
      for (int o = 0; o < 4; o++) begin
        if (gnt_any[o]) begin
          pndng[o]    <= 1'b1;
          data_out[o] <= {row_c, col_c, head[gnt_idx[o]][pckg_sz-9:0]};
          rr_ptr[o]   <= gnt_idx[o] + 2'd1;
        end else if (pop[o]) begin
          pndng[o]    <= 1'b0;
        end else begin
          pndng[o]    <= pndng[o];
        end
      end
    end
  end

endmodule

// File: doc/node_xy_switch.md
NODE_XY_SWITCH -- requirements
Module: node_xy_switch

Interface
REQ-001 Parameter pckg_sz, default 40, packet width in bits.
REQ-002 Parameter fifo_depth, default 4, input FIFO entries per port.
REQ-003 Parameter id_row, default 1, row of this node.
REQ-004 Parameter id_column, default 1, column of this node.
REQ-005 Parameter bdcst, default {pckg_sz-18{1'b1}}, payload value marking broadcast.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 pndng_in  input  4  upstream head-valid per port; port index 0=N, 1=S, 2=E, 3=W.
REQ-009 data_in  input  4 x pckg_sz  upstream head data per port.
REQ-010 popin  output  4  pop strobe to upstream per port.
REQ-011 pndng  output  4  output holding register valid per port.
REQ-012 data_out  output  4 x pckg_sz  output holding register data per port.
REQ-013 pop  input  4  downstream consume strobe per port.
REQ-014 err  output  1  one-cycle pulse on dropped self-addressed packet.

Function
REQ-015 Header fields SHALL be: [pckg_sz-1:pckg_sz-8] Nxt_jump, [pckg_sz-9:pckg_sz-12] target row, [pckg_sz-13:pckg_sz-16] target column, [pckg_sz-17] mode (1=row-first, 0=column-first), [pckg_sz-18:0] payload.
REQ-016 popin[p] SHALL be combinational pndng_in[p] AND (count[p] < fifo_depth); no push on a full FIFO, even if its head leaves in the same cycle.
REQ-017 At each edge with popin[p]=1, data_in[p] SHALL be written to FIFO p.
REQ-018 Routing of FIFO head, row-first: target row < id_row -> N; > -> S; equal -> target col < id_column -> W, > -> E.
REQ-019 Column-first mode SHALL compare columns first, then rows, with the same direction mapping.
REQ-020 Target equal to (id_row, id_column), non-broadcast: head SHALL be popped without output, err pulsed high for exactly one cycle.
REQ-021 Payload equal to bdcst: head SHALL target every port except its arrival port.
REQ-022 Each input SHALL keep a 4-bit sent mask; broadcast copies are delivered per port independently; head popped on the edge its last target copy is loaded; mask then cleared.
REQ-023 Each output SHALL own a round-robin arbiter over requesting inputs; after a grant to input i, priority starts at i+1 mod 4; reset pointer 0.
REQ-024 An output holding register SHALL load when pndng=0 or pop=1 in the same cycle (back-to-back throughput of one packet per cycle per port).
REQ-025 On load, Nxt_jump SHALL be rewritten to {id_row[3:0], id_column[3:0]}; all other bits unchanged.
REQ-026 pop[p] while pndng[p]=0 SHALL be ignored.
REQ-027 Minimum latency: packet captured at edge k SHALL show pndng=1 after edge k+1 when uncontended.
REQ-028 A blocked output (pndng=1, pop=0) SHALL stall only inputs whose head targets it; other inputs proceed.
REQ-029 Per-input ordering SHALL be preserved per output port.

Reset
REQ-030 While reset=0: all FIFOs empty, counts 0, sent masks 0, arbiter pointers 0, pndng=0, data_out=0, err=0, popin=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered packets immediately, without waiting for a clock edge.
REQ-032 First capture SHALL occur at the first rising edge with reset=1.

Verification
REQ-033 Node (1,1), N input header row=3,col=2,mode=1, payload 5 -> S output pndng=1 two edges after popin, Nxt_jump=0x11, payload 5.
REQ-034 Same target with mode=0 -> E output; target row=1,col=0 -> W output.
REQ-035 W, N, E heads all targeting S simultaneously, pop held 1 -> S emits N, E, W in strict round-robin order from pointer 0, one per cycle.
REQ-036 N input payload=bdcst, E output stalled (pop=0) -> S and W copies delivered, N head retained; E popped -> E copy delivered, N FIFO count decrements.
REQ-037 Fill S FIFO with 4 packets to a stalled output -> popin[1]=0 while pndng_in[1]=1; one downstream pop -> popin[1]=1 on the following cycle.
REQ-038 Packet addressed to (1,1) -> err high exactly one cycle, no pndng on any output; reset=0 with 3 packets buffered -> all pndng=0 immediately.
